// File: rtl/rand_sched_pkg.sv
// Shared types and helpers for the random-source scheduler.
//   state_e       : scheduler FSM states
//   INIT_SEED_DEF : default LFSR seed after reset and for zero entropy
//   mask_of()     : smallest all-ones mask (2^k-1) covering a limit
//   idx_width()   : bit width of a requester index (at least 1)
package rand_pkg;

  typedef enum logic [1:0] {
    SEED = 2'd0,
    IDLE = 2'd1,
    DRAW = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic [7:0] INIT_SEED_DEF = 8'hA5;

  // Smear the highest set bit downward: the result is the smallest 2^k-1 >= lim.
  function automatic logic [7:0] mask_of(input logic [7:0] lim);
    logic [7:0] m;
    m = lim | (lim >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    return m;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rand_sched_if.sv
// Request/response bundle between game-logic requesters and rand_sched.
//   req   : per-requester request level (held until gnt)
//   limit : inclusive upper bound per requester, slice i = limit[8*i+7:8*i]
//   gnt   : one-hot grant, high for one cycle together with valid
//   valid : rdata is valid this cycle
//   rdata : random result in [0, limit of granted requester]
interface rand_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] limit;
  logic [NREQ-1:0]   gnt;
  logic              valid;
  logic [7:0]        rdata;

  modport master (output req, limit, input gnt, valid, rdata);
  modport slave  (input req, limit, output gnt, valid, rdata);
endinterface

// File: rtl/rand_sched_rr_arbiter.sv
// Combinational round-robin pick.
//   req      : request vector
//   last     : index of the most recently served requester
//   pick     : one-hot winner, searching from last+1 modulo NREQ
//   pick_idx : binary index of the winner
//   any      : at least one request is asserted
module rr_arbiter
  import rand_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] pick,
  output logic [IW-1:0]   pick_idx,
  output logic            any
);

  always_comb begin
    logic [IW-1:0] j;
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    j        = last;
    // Walk NREQ positions starting after last; the first hit wins.
    for (int off = 0; off < NREQ; off++) begin
      j = (j == IW'(NREQ - 1)) ? '0 : j + IW'(1);
      if (!any && req[j]) begin
        any      = 1'b1;
        pick[j]  = 1'b1;
        pick_idx = j;
      end
    end
  end

endmodule

// File: rtl/rand_sched.sv
// Round-robin scheduler sharing one 8-bit LFSR among several requesters.
// Owns the LFSR reset/seed pins, reseeds at power-up and on demand, and
// returns a uniform byte in [0, limit] by mask-and-reject sampling with a
// bounded number of tries.
//   clk, rst      : clock, synchronous active-high reset
//   bus           : requester bundle (req/limit in, gnt/valid/rdata out)
//   reseed        : one-cycle pulse requesting a reseed from entropy
//   entropy       : seed source captured when a reseed is serviced
//   rng_rst       : LFSR reset pin (one cycle high per seeding)
//   rng_seed      : LFSR seed pin
//   rng_value     : current LFSR output
//
// state | meaning
// SEED  | rng_rst high for one cycle, LFSR loads rng_seed
// IDLE  | service pending reseed first, otherwise accept a request
// DRAW  | sample rng_value under mask, accept or reject
// RESP  | valid/gnt high, remember the served requester
module rand_sched
  import rand_pkg::*;
#(
  parameter int         NREQ      = 4,
  parameter int         MAX_TRIES = 8,
  parameter logic [7:0] INIT_SEED = INIT_SEED_DEF
) (
  input  logic       clk,
  input  logic       rst,
  rand_sched_if.slave bus,
  input  logic       reseed,
  input  logic [7:0] entropy,
  output logic       rng_rst,
  output logic [7:0] rng_seed,
  input  logic [7:0] rng_value
);

  localparam int IW = idx_width(NREQ);
  localparam int TW = $clog2(MAX_TRIES + 1);

  state_e          state, state_nx;
  logic [IW-1:0]   idx, idx_nx;
  logic [IW-1:0]   last, last_nx;
  logic [NREQ-1:0] sel, sel_nx;
  logic [7:0]      lim, lim_nx;
  logic [7:0]      mask, mask_nx;
  logic [TW-1:0]   tries, tries_nx;
  logic            pend, pend_nx;

  logic [NREQ-1:0] gnt_q, gnt_nx;
  logic            valid_q, valid_nx;
  logic [7:0]      rdata_q, rdata_nx;
  logic            rng_rst_nx;
  logic [7:0]      rng_seed_nx;

  logic [NREQ-1:0] pick;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic [7:0]      v;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req      (bus.req),
    .last     (last),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  assign v = rng_value & mask;

  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    last_nx     = last;
    sel_nx      = sel;
    lim_nx      = lim;
    mask_nx     = mask;
    tries_nx    = tries;
    pend_nx     = pend | reseed;
    rdata_nx    = rdata_q;
    rng_seed_nx = rng_seed;

    case (state)
      SEED: state_nx = IDLE;

      IDLE: begin
        if (pend) begin
          // Clearing here also swallows a pulse landing on this same edge.
          rng_seed_nx = (entropy == 8'h00) ? INIT_SEED : entropy;
          pend_nx     = 1'b0;
          state_nx    = SEED;
        end else if (pick_any) begin
          idx_nx   = pick_idx;
          sel_nx   = pick;
          lim_nx   = bus.limit[{pick_idx, 3'b000} +: 8];
          mask_nx  = mask_of(lim_nx);
          tries_nx = '0;
          state_nx = DRAW;
        end
      end

      DRAW: begin
        if (v <= lim) begin
          rdata_nx = v;
          state_nx = RESP;
        end else begin
          tries_nx = tries + TW'(1);
          // mask <= 2*lim+1, so a rejected v folds back into [0, lim].
          if (tries_nx == TW'(MAX_TRIES)) begin
            rdata_nx = v - lim - 8'd1;
            state_nx = RESP;
          end
        end
      end

      RESP: begin
        last_nx  = idx;
        state_nx = IDLE;
      end

      default: state_nx = SEED;
    endcase

    // Outputs are registered from the next state so they line up with it.
    rng_rst_nx = (state_nx == SEED);
    valid_nx   = (state_nx == RESP);
    gnt_nx     = (state_nx == RESP) ? sel_nx : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SEED;
      idx      <= '0;
      last     <= IW'(NREQ - 1);
      sel      <= '0;
      lim      <= '0;
      mask     <= '0;
      tries    <= '0;
      pend     <= 1'b0;
      gnt_q    <= '0;
      valid_q  <= 1'b0;
      rdata_q  <= '0;
      rng_rst  <= 1'b1;
      rng_seed <= INIT_SEED;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      last     <= last_nx;
      sel      <= sel_nx;
      lim      <= lim_nx;
      mask     <= mask_nx;
      tries    <= tries_nx;
      pend     <= pend_nx;
      gnt_q    <= gnt_nx;
      valid_q  <= valid_nx;
      rdata_q  <= rdata_nx;
      rng_rst  <= rng_rst_nx;
      rng_seed <= rng_seed_nx;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.valid = valid_q;
  assign bus.rdata = rdata_q;

endmodule

// File: doc/rand_sched.md
# rand_sched

Round-robin scheduler that shares the single 8-bit LFSR random source among several game subsystems, such as hunger events, mood drift, mini-games and sickness rolls. It owns the LFSR's reset and seed pins and performs power-up and on-demand reseeding. It serves one requester at a time and returns a uniformly distributed byte in `[0, limit]` using mask-and-reject sampling. It sits between the LFSR instance and the game-logic FSMs.

## Interface
- `NREQ`, default 4: number of requesters.
- `MAX_TRIES`, default 8: maximum LFSR samples per request before the fallback applies.
- `INIT_SEED`, default 8'hA5: seed used at reset, and substituted for any zero seed.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `req` in NREQ: per-requester request level.
- `limit` in NREQ*8: inclusive upper bound per requester; slice i is `limit[8*i+7:8*i]`.
- `gnt` out NREQ: one-hot, high for one cycle together with `valid`.
- `valid` out 1: `rdata` is valid this cycle.
- `rdata` out 8: random result.
- `reseed` in 1: single-cycle pulse requesting a reseed from `entropy`.
- `entropy` in 8: seed source sampled when a reseed is serviced.
- `rng_rst` out 1: drives the LFSR reset pin.
- `rng_seed` out 8: drives the LFSR seed pin.
- `rng_value` in 8: current LFSR output.

## Operation
- States:
  - SEED: `rng_rst`=1 for exactly one cycle, then go to IDLE.
  - IDLE: arbitrate between pending reseed and requests.
  - DRAW: sample `rng_value` and test it.
  - RESP: present the result.
- Reset: all outputs are registered. Reset values are `gnt`=0, `valid`=0, `rdata`=0, `rng_rst`=1, `rng_seed`=INIT_SEED. Reset leaves the block in SEED, so the LFSR is reseeded with INIT_SEED on the first cycle after `rst` falls.
- Reseed:
  - A `reseed` pulse in any state sets `reseed_pend`.
  - In IDLE, `reseed_pend` has priority over requests. The block captures `entropy` into `rng_seed`, replacing 0 with INIT_SEED, clears `reseed_pend` and goes to SEED.
  - A pulse arriving on the same cycle it is serviced is absorbed; it does not cause a second reseed.
- Arbitration in IDLE:
  - If no reseed is pending and `req` is nonzero, pick the first asserted index searching from `last+1` modulo NREQ.
  - Latch `idx`, `lim=limit[idx]` and `mask` = smallest 2^k−1 ≥ `lim`.
  - Clear `tries` and go to DRAW.
- DRAW:
  - Compute `v = rng_value & mask`.
  - If `v <= lim`, register `rdata=v` and go to RESP.
  - Otherwise increment `tries`. If `tries` reaches MAX_TRIES on this sample, register `rdata = v − (lim+1)` and go to RESP; this is always ≤ `lim` because `mask ≤ 2·lim+1`. Otherwise stay in DRAW.
- RESP: `valid`=1, `gnt[idx]`=1, `last=idx`, then go to IDLE.
- Requesters hold `req` until they see their `gnt`. A `req` dropped before grant is simply not served. A `req` still high in the cycle after `gnt` counts as a new request.
- `limit` is sampled only at acceptance; later changes do not affect an in-flight request.
- Edge cases:
  - `lim`=0 gives `mask`=0 and `rdata`=0 on the first DRAW.
  - `lim`=255 gives `mask`=FF and never rejects.
- Reset mid-DRAW or mid-RESP discards the request and does not produce a `gnt`.

## Timing
- Request sampled in IDLE at edge N: DRAW samples at N+1, and `valid`/`gnt` are high during cycle N+2 when there is no rejection.
- Each rejection adds 1 cycle. Worst case `valid` is MAX_TRIES+1 cycles after acceptance.
- Back-to-back service: the next acceptance occurs in the IDLE cycle after RESP. Minimum spacing between grants is 3 cycles.
- Reseed costs 2 cycles (IDLE capture, then SEED). `rng_rst` is high for exactly one cycle, and `rng_seed` is stable throughout that cycle.

## Structure
- `rand_pkg`:
  - state enum `{SEED, IDLE, DRAW, RESP}`;
  - `INIT_SEED_DEF`;
  - function `mask_of(input [7:0] lim)`, which returns smallest 2^k−1 ≥ `lim`.
- Sub-module `rr_arbiter`: NREQ-wide round-robin pick from `req` and `last`, producing a one-hot index. It is combinational, and `last` is owned by `rand_sched`.
- Target implementation size: about 200 lines of RTL.

## Test plan
- Reset, then idle:
  - `rng_rst`=1 with `rng_seed`=A5 through reset and for one cycle after;
  - then `rng_rst`=0, with `gnt`, `valid` and `rdata` all 0.
- `req`=0001, `limit0`=255, bench drives `rng_value`=8'h3C → `gnt`=0001 and `rdata`=3C exactly 2 cycles after acceptance.
- `limit0`=9 (`mask` 0F), `rng_value` sequence 0E, 0B, 07 → two rejections, then `rdata`=07 at acceptance+4.
- `limit0`=9, `rng_value` held at FF with MAX_TRIES=8 → fallback `rdata`=0F−10=05 at acceptance+9.
- `req`=1111 held continuously, `limit`=255 for all requesters → grants in order 0001, 0010, 0100, 1000, 0001, each 3 cycles apart.
- Reseed handling:
  - `reseed` with `entropy`=00 while busy → after RESP, `rng_seed`=A5 with a one-cycle `rng_rst`, then pending requests resume.
  - `entropy`=5A → `rng_seed`=5A.
